// File: rtl/rc4_pkg.sv
// Shared types and widths for the RC4 key-search datapath.
package rc4_pkg;

    localparam int unsigned KEY_W    = 24;
    localparam int unsigned S_ADDR_W = 8;
    localparam int unsigned S_DATA_W = 8;

    typedef enum logic [2:0] {
        PhaseIdle      = 3'd0,
        PhaseInit      = 3'd1,
        PhaseShuffle   = 3'd2,
        PhaseDecrypt   = 3'd3,
        PhaseFound     = 3'd4,
        PhaseExhausted = 3'd5
    } phase_t;

endpackage

// File: rtl/s_mem_port_mux.sv
// Combinational S-memory grant: routes the active phase's request to the single memory port.
module s_mem_port_mux
    import rc4_pkg::*;
(
    input  phase_t                phase,
    input  logic [S_ADDR_W-1:0]   init_address,
    input  logic [S_DATA_W-1:0]   init_data,
    input  logic                  init_wren,
    input  logic [S_ADDR_W-1:0]   shuffle_address,
    input  logic [S_DATA_W-1:0]   shuffle_data,
    input  logic                  shuffle_wren,
    input  logic [S_ADDR_W-1:0]   decrypt_address,
    input  logic [S_DATA_W-1:0]   decrypt_data,
    input  logic                  decrypt_wren,
    output logic [S_ADDR_W-1:0]   mem_address,
    output logic [S_DATA_W-1:0]   mem_data,
    output logic                  mem_wren
);

    always_comb begin
        mem_address = '0;
        mem_data    = '0;
        mem_wren    = 1'b0;
        case (phase)
            PhaseInit: begin
                mem_address = init_address;
                mem_data    = init_data;
                mem_wren    = init_wren;
            end
            PhaseShuffle: begin
                mem_address = shuffle_address;
                mem_data    = shuffle_data;
                mem_wren    = shuffle_wren;
            end
            PhaseDecrypt: begin
                mem_address = decrypt_address;
                mem_data    = decrypt_data;
                mem_wren    = decrypt_wren;
            end
            default: begin
                mem_address = '0;
                mem_data    = '0;
                mem_wren    = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/rc4_phase_sequencer.sv
// Sequences init -> shuffle -> decrypt per candidate key and grants S memory to the active phase.
module rc4_phase_sequencer
    import rc4_pkg::*;
#(
    parameter int unsigned      KEY_W     = rc4_pkg::KEY_W,
    parameter logic [KEY_W-1:0] KEY_START = 24'h000000,
    parameter logic [KEY_W-1:0] KEY_MAX   = 24'h3FFFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    output logic                init_start,
    output logic                shuffle_start,
    output logic                decrypt_start,
    input  logic                init_finish,
    input  logic                shuffle_finish,
    input  logic                decrypt_finish,
    input  logic                decrypt_ok,
    input  logic [S_ADDR_W-1:0] init_address,
    input  logic [S_DATA_W-1:0] init_data,
    input  logic                init_wren,
    input  logic [S_ADDR_W-1:0] shuffle_address,
    input  logic [S_DATA_W-1:0] shuffle_data,
    input  logic                shuffle_wren,
    input  logic [S_ADDR_W-1:0] decrypt_address,
    input  logic [S_DATA_W-1:0] decrypt_data,
    input  logic                decrypt_wren,
    output logic [S_ADDR_W-1:0] mem_address,
    output logic [S_DATA_W-1:0] mem_data,
    output logic                mem_wren,
    output logic [KEY_W-1:0]    secret_key,
    output logic [2:0]          phase,
    output logic                busy,
    output logic                found,
    output logic                exhausted
);

    phase_t           state_q, state_d;
    logic [KEY_W-1:0] key_q, key_d;
    // High only in the first cycle of a phase state; also masks stale finish levels.
    logic             launch_q, launch_d;

    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        case (state_q)
            PhaseIdle, PhaseFound, PhaseExhausted: begin
                if (start) begin
                    state_d = PhaseInit;
                    key_d   = KEY_START;
                end
            end
            PhaseInit: begin
                if (init_finish && !launch_q) state_d = PhaseShuffle;
            end
            PhaseShuffle: begin
                if (shuffle_finish && !launch_q) state_d = PhaseDecrypt;
            end
            PhaseDecrypt: begin
                if (decrypt_finish && !launch_q) begin
                    if (decrypt_ok) begin
                        state_d = PhaseFound;
                    end else if (key_q == KEY_MAX) begin
                        state_d = PhaseExhausted;
                    end else begin
                        state_d = PhaseInit;
                        key_d   = key_q + 1'b1;
                    end
                end
            end
            default: state_d = PhaseIdle;
        endcase
    end

    assign launch_d = (state_d != state_q) &&
                      (state_d inside {PhaseInit, PhaseShuffle, PhaseDecrypt});

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= PhaseIdle;
            key_q    <= KEY_START;
            launch_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            key_q    <= key_d;
            launch_q <= launch_d;
        end
    end

    assign init_start    = launch_q && (state_q == PhaseInit);
    assign shuffle_start = launch_q && (state_q == PhaseShuffle);
    assign decrypt_start = launch_q && (state_q == PhaseDecrypt);

    assign secret_key = key_q;
    assign phase      = state_q;
    assign busy       = state_q inside {PhaseInit, PhaseShuffle, PhaseDecrypt};
    assign found      = (state_q == PhaseFound);
    assign exhausted  = (state_q == PhaseExhausted);

    s_mem_port_mux u_mux (
        .phase           (state_q),
        .init_address    (init_address),
        .init_data       (init_data),
        .init_wren       (init_wren),
        .shuffle_address (shuffle_address),
        .shuffle_data    (shuffle_data),
        .shuffle_wren    (shuffle_wren),
        .decrypt_address (decrypt_address),
        .decrypt_data    (decrypt_data),
        .decrypt_wren    (decrypt_wren),
        .mem_address     (mem_address),
        .mem_data        (mem_data),
        .mem_wren        (mem_wren)
    );

endmodule

// File: tb/tb_rc4_phase_sequencer.sv
// Directed bench for rc4_phase_sequencer: per-cycle vector table plus phase-model sequences.
module tb_rc4_phase_sequencer;
    import rc4_pkg::*;

    localparam int BIG = 1 << 30;

    logic        clk = 1'b0;
    logic        reset, start;
    logic        init_start, shuffle_start, decrypt_start;
    logic        init_finish, shuffle_finish, decrypt_finish, decrypt_ok;
    logic [7:0]  init_address = 8'h11, init_data = 8'hA1;
    logic [7:0]  shuffle_address = 8'h22, shuffle_data = 8'hB2;
    logic [7:0]  decrypt_address = 8'h33, decrypt_data = 8'hC3;
    logic        init_wren = 1'b1, shuffle_wren = 1'b1, decrypt_wren = 1'b0;
    logic [7:0]  mem_address, mem_data;
    logic        mem_wren;
    logic [23:0] secret_key;
    logic [2:0]  phase;
    logic        busy, found, exhausted;

    // Second instance with a tiny key space for the exhaustion case.
    logic        b_start, b_fin, b_ok;
    logic        b_init_start, b_shuffle_start, b_decrypt_start;
    logic [7:0]  b_mem_address, b_mem_data;
    logic        b_mem_wren;
    logic [23:0] b_secret_key;
    logic [2:0]  b_phase;
    logic        b_busy, b_found, b_exhausted;

    always #5 clk = ~clk;

    rc4_phase_sequencer dut (
        .clk(clk), .reset(reset), .start(start),
        .init_start(init_start), .shuffle_start(shuffle_start), .decrypt_start(decrypt_start),
        .init_finish(init_finish), .shuffle_finish(shuffle_finish),
        .decrypt_finish(decrypt_finish), .decrypt_ok(decrypt_ok),
        .init_address(init_address), .init_data(init_data), .init_wren(init_wren),
        .shuffle_address(shuffle_address), .shuffle_data(shuffle_data),
        .shuffle_wren(shuffle_wren),
        .decrypt_address(decrypt_address), .decrypt_data(decrypt_data),
        .decrypt_wren(decrypt_wren),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren),
        .secret_key(secret_key), .phase(phase), .busy(busy), .found(found),
        .exhausted(exhausted)
    );

    rc4_phase_sequencer #(.KEY_START(24'h000005), .KEY_MAX(24'h000006)) dut_b (
        .clk(clk), .reset(reset), .start(b_start),
        .init_start(b_init_start), .shuffle_start(b_shuffle_start),
        .decrypt_start(b_decrypt_start),
        .init_finish(b_fin), .shuffle_finish(b_fin), .decrypt_finish(b_fin),
        .decrypt_ok(b_ok),
        .init_address(init_address), .init_data(init_data), .init_wren(init_wren),
        .shuffle_address(shuffle_address), .shuffle_data(shuffle_data),
        .shuffle_wren(shuffle_wren),
        .decrypt_address(decrypt_address), .decrypt_data(decrypt_data),
        .decrypt_wren(decrypt_wren),
        .mem_address(b_mem_address), .mem_data(b_mem_data), .mem_wren(b_mem_wren),
        .secret_key(b_secret_key), .phase(b_phase), .busy(b_busy), .found(b_found),
        .exhausted(b_exhausted)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [16:0] exp_mem(input logic [2:0] ph);
        case (ph)
            3'd1:    return {8'h11, 8'hA1, 1'b1};
            3'd2:    return {8'h22, 8'hB2, 1'b1};
            3'd3:    return {8'h33, 8'hC3, 1'b0};
            default: return 17'd0;
        endcase
    endfunction

    typedef struct {
        logic        rst, st, fi, fs, fd, ok;
        logic [2:0]  ph;
        logic [2:0]  pulses;
        logic [23:0] key;
    } vec_t;

    function automatic vec_t mk(input logic [5:0] ins, input logic [2:0] ph,
                                input logic [2:0] pulses, input logic [23:0] key);
        vec_t v;
        {v.rst, v.st, v.fi, v.fs, v.fd, v.ok} = ins;
        v.ph = ph; v.pulses = pulses; v.key = key;
        return v;
    endfunction

    // Phase models: each finish fires 5 cycles after its start pulse (pulse or held level).
    int          cyc, due_i, due_s, due_d, found_cyc, act;
    bit          level_mode, spur;
    logic [23:0] pass_key;
    int          i_cyc[$], s_cyc[$], d_cyc[$];
    logic [23:0] i_key[$];
    string       order;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (level_mode) begin
            init_finish    = (cyc >= due_i);
            shuffle_finish = (cyc >= due_s);
            decrypt_finish = (cyc >= due_d);
        end else begin
            init_finish    = (cyc == due_i);
            shuffle_finish = (cyc == due_s);
            decrypt_finish = (cyc == due_d);
        end
        if (spur && cyc == 3) shuffle_finish = 1'b1;
        if (init_start) begin
            due_i = cyc + 5; i_cyc.push_back(cyc); i_key.push_back(secret_key);
            order = {order, "I"}; act = 1;
        end
        if (shuffle_start) begin
            due_s = cyc + 5; s_cyc.push_back(cyc); order = {order, "S"}; act = 2;
        end
        if (decrypt_start) begin
            due_d = cyc + 5; d_cyc.push_back(cyc); order = {order, "D"}; act = 3;
        end
        if (found && found_cyc < 0) found_cyc = cyc;
        if (found || exhausted) act = 0;
        decrypt_ok = (secret_key == pass_key);
        chk("grant", {47'd0, mem_address, mem_data, mem_wren}, {47'd0, exp_mem(act[2:0])});
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0;
        init_finish = 1'b0; shuffle_finish = 1'b0; decrypt_finish = 1'b0; decrypt_ok = 1'b0;
        due_i = BIG; due_s = BIG; due_d = BIG; cyc = 0; act = 0; found_cyc = -1;
        i_cyc.delete(); s_cyc.delete(); d_cyc.delete(); i_key.delete(); order = "";
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic run_search(input int budget);
        int n = 0;
        while (!(found || exhausted) && n < budget) begin
            tick();
            n++;
        end
        if (!(found || exhausted)) chk("search_timeout", 64'd0, 64'd1);
    endtask

    vec_t vecs[$];
    logic [49:0] got, want;

    initial begin
        reset = 1'b1; start = 1'b0; b_start = 1'b0; b_fin = 1'b1; b_ok = 1'b0;
        init_finish = 1'b0; shuffle_finish = 1'b0; decrypt_finish = 1'b0; decrypt_ok = 1'b0;

        // ins = {rst, st, fi, fs, fd, ok}; expected phase, {i,s,d} pulses, key after the edge
        vecs.push_back(mk(6'b100000, 3'd0, 3'b000, 24'd0));
        for (int i = 0; i < 10; i++) vecs.push_back(mk(6'b000000, 3'd0, 3'b000, 24'd0));
        vecs.push_back(mk(6'b010000, 3'd1, 3'b100, 24'd0));
        vecs.push_back(mk(6'b001100, 3'd1, 3'b000, 24'd0)); // finish masked in launch cycle
        vecs.push_back(mk(6'b000100, 3'd1, 3'b000, 24'd0)); // non-active finish ignored
        vecs.push_back(mk(6'b010000, 3'd1, 3'b000, 24'd0)); // start ignored while busy
        vecs.push_back(mk(6'b001000, 3'd2, 3'b010, 24'd0));
        vecs.push_back(mk(6'b000100, 3'd2, 3'b000, 24'd0));
        vecs.push_back(mk(6'b000110, 3'd3, 3'b001, 24'd0));
        vecs.push_back(mk(6'b000010, 3'd3, 3'b000, 24'd0));
        vecs.push_back(mk(6'b000010, 3'd1, 3'b100, 24'd1)); // failed key increments
        vecs.push_back(mk(6'b001000, 3'd1, 3'b000, 24'd1));
        vecs.push_back(mk(6'b001000, 3'd2, 3'b010, 24'd1));
        vecs.push_back(mk(6'b000100, 3'd2, 3'b000, 24'd1));
        vecs.push_back(mk(6'b000100, 3'd3, 3'b001, 24'd1));
        vecs.push_back(mk(6'b000011, 3'd3, 3'b000, 24'd1));
        vecs.push_back(mk(6'b000011, 3'd4, 3'b000, 24'd1));
        vecs.push_back(mk(6'b000000, 3'd4, 3'b000, 24'd1));
        vecs.push_back(mk(6'b010000, 3'd1, 3'b100, 24'd0)); // restart from FOUND
        vecs.push_back(mk(6'b000000, 3'd1, 3'b000, 24'd0));
        vecs.push_back(mk(6'b001000, 3'd2, 3'b010, 24'd0));
        vecs.push_back(mk(6'b000000, 3'd2, 3'b000, 24'd0));
        vecs.push_back(mk(6'b110000, 3'd0, 3'b000, 24'd0)); // reset beats start mid-shuffle
        vecs.push_back(mk(6'b010000, 3'd1, 3'b100, 24'd0));
        vecs.push_back(mk(6'b100000, 3'd0, 3'b000, 24'd0));

        foreach (vecs[i]) begin
            {reset, start, init_finish, shuffle_finish, decrypt_finish, decrypt_ok} =
                {vecs[i].rst, vecs[i].st, vecs[i].fi, vecs[i].fs, vecs[i].fd, vecs[i].ok};
            @(posedge clk);
            #1;
            got  = {phase, init_start, shuffle_start, decrypt_start, busy, found, exhausted,
                    secret_key, mem_address, mem_data, mem_wren};
            want = {vecs[i].ph, vecs[i].pulses, (vecs[i].ph inside {3'd1, 3'd2, 3'd3}),
                    (vecs[i].ph == 3'd4), (vecs[i].ph == 3'd5), vecs[i].key,
                    exp_mem(vecs[i].ph)};
            chk($sformatf("vec%0d", i), {14'd0, got}, {14'd0, want});
        end

        // Pass on key 0 with 5-cycle pulse models: launches at 1, 7, 13, FOUND at 19.
        level_mode = 1'b0; spur = 1'b0; pass_key = 24'd0;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        run_search(100);
        chk("a_init_cnt", i_cyc.size(), 1);
        chk("a_init_cyc", (i_cyc.size() > 0) ? i_cyc[0] : -1, 1);
        chk("a_shuf_cyc", (s_cyc.size() > 0) ? s_cyc[0] : -1, 7);
        chk("a_decr_cyc", (d_cyc.size() > 0) ? d_cyc[0] : -1, 13);
        chk("a_found_cyc", found_cyc, 19);
        chk("a_key", secret_key, 24'd0);

        // Keys 0..2 fail, key 3 passes.
        pass_key = 24'd3;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        run_search(300);
        chk("b_init_cnt", i_cyc.size(), 4);
        for (int k = 0; k < 4; k++)
            chk($sformatf("b_key_at_init%0d", k), (i_cyc.size() > k) ? i_key[k] : 24'hFFFFFF, k);
        chk("b_found", {found, exhausted}, 2'b10);
        chk("b_key", secret_key, 24'd3);
        chk("b_found_cyc", found_cyc, 73);

        // Held finish levels plus a spurious shuffle_finish during INIT.
        level_mode = 1'b1; spur = 1'b1; pass_key = 24'd1;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        run_search(300);
        chk("d_order", (order == "ISDISD") ? 1 : 0, 1);
        chk("d_found", found, 1'b1);
        chk("d_key", secret_key, 24'd1);
        level_mode = 1'b0; spur = 1'b0;

        // Reset mid-SHUFFLE of key 1 with shuffle_wren high.
        pass_key = 24'hFFFFFF;
        do_reset();
        start = 1'b1; tick(); start = 1'b0;
        for (int n = 0; n < 100 && s_cyc.size() < 2; n++) tick();
        chk("e_reached_shuffle2", s_cyc.size(), 2);
        tick();
        tick();
        chk("e_wren_before", mem_wren, 1'b1);
        start = 1'b1; tick(); start = 1'b0;
        chk("e_busy_start_ignored", {phase, 29'd0, i_cyc.size()}, {3'd2, 29'd0, 32'd2});
        chk("e_key_before", secret_key, 24'd1);
        reset = 1'b1; act = 0; tick(); reset = 1'b0;
        chk("e_after_reset",
            {phase, busy, mem_wren, init_start, shuffle_start, decrypt_start, secret_key},
            {3'd0, 1'b0, 1'b0, 3'b000, 24'd0});

        // Exhaustion on the small key space with every finish held high.
        b_start = 1'b1;
        @(posedge clk);
        #1;
        b_start = 1'b0;
        i_key.delete();
        if (b_init_start) i_key.push_back(b_secret_key);
        for (int n = 0; n < 100 && !b_exhausted; n++) begin
            @(posedge clk);
            #1;
            if (b_init_start) i_key.push_back(b_secret_key);
        end
        chk("c_init_cnt", i_key.size(), 2);
        chk("c_key0", (i_key.size() > 0) ? i_key[0] : 24'hFFFFFF, 24'd5);
        chk("c_key1", (i_key.size() > 1) ? i_key[1] : 24'hFFFFFF, 24'd6);
        chk("c_state", {b_exhausted, b_found, b_busy, b_phase}, {3'b100, 3'd5});
        chk("c_key_held", b_secret_key, 24'd6);
        chk("c_mem_idle", {b_mem_address, b_mem_data, b_mem_wren}, 17'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/rc4_phase_sequencer.md
# rc4_phase_sequencer

Top-level controller for the RC4 key-search datapath. It sequences the three phase engines (memory init, KSA shuffle, decrypt/check) in order, grants the single-port S memory to whichever phase is active, and steps through the candidate secret keys until decrypt reports a valid plaintext or the key space is exhausted. It replaces ad-hoc button-driven phase starts with one `start` pulse.

## Interface

Parameters:
- `KEY_W`, 24: secret key width.
- `KEY_START`, 24'h000000: first candidate key.
- `KEY_MAX`, 24'h3FFFFF: last candidate key (inclusive).

Ports:
- `clk`  in  1  single system clock; all logic on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to begin a search.
- `init_start` / `shuffle_start` / `decrypt_start`  out  1 each  one-cycle phase launch pulses.
- `init_finish` / `shuffle_finish` / `decrypt_finish`  in  1 each  phase completion (pulse or level).
- `decrypt_ok`  in  1  plaintext valid; sampled only with `decrypt_finish`.
- `init_address`, `init_data`, `shuffle_address`, `shuffle_data`, `decrypt_address`, `decrypt_data`  in  8 each  per-phase memory requests.
- `init_wren`, `shuffle_wren`, `decrypt_wren`  in  1 each  per-phase write enables.
- `mem_address`, `mem_data`  out  8 each  to S memory.
- `mem_wren`  out  1  to S memory.
- `secret_key`  out  KEY_W  current candidate key, fed to shuffle and decrypt.
- `phase`  out  3  current state (package encoding).
- `busy`  out  1  high in INIT, SHUFFLE, DECRYPT.
- `found`  out  1  high in FOUND.
- `exhausted`  out  1  high in EXHAUSTED.

## Operation

- States: IDLE, INIT, SHUFFLE, DECRYPT, FOUND, EXHAUSTED.
- IDLE/FOUND/EXHAUSTED + `start` -> INIT; `secret_key` loads `KEY_START`; `found` and `exhausted` clear.
- INIT + `init_finish` -> SHUFFLE.
- SHUFFLE + `shuffle_finish` -> DECRYPT.
- DECRYPT + `decrypt_finish`:
  - `decrypt_ok`=1 -> FOUND; key held.
  - `decrypt_ok`=0 and key != `KEY_MAX` -> INIT with key+1.
  - `decrypt_ok`=0 and key == `KEY_MAX` -> EXHAUSTED; key held.
- Each entry into INIT, SHUFFLE or DECRYPT emits exactly one start pulse for that phase in the first cycle of the state.
- A finish input is ignored in the cycle the matching start pulse is high. This masks a stale level left over from the previous run. Finish inputs for non-active phases are always ignored.
- `start` is ignored while `busy`.
- Memory grant is decoded from the registered state:
  - INIT, SHUFFLE, DECRYPT: the matching phase's address, data and wren pass through to `mem_*`.
  - All other states: `mem_address`=0, `mem_data`=0, `mem_wren`=0.
- Read data (`q`) is not routed by this block; S memory `q` fans out to all phases directly.
- Key increment is unsigned, KEY_W wide. No wrap occurs because `KEY_MAX` is checked first.

## Timing

- Reset values: state IDLE, `secret_key`=`KEY_START`, all start pulses 0, `mem_*`=0, `busy`=`found`=`exhausted`=0, `phase`=IDLE.
- `start` high in cycle 0 -> state INIT and `init_start`=1 in cycle 1.
- Finish accepted in cycle n -> next state and its start pulse in cycle n+1. Sequencer overhead is 1 cycle per phase, 3 cycles per key.
- Failed key: the key increments in the same cycle `init_start` pulses. Shuffle therefore always sees the new key.
- Grant mux is combinational from state, with zero added latency on memory requests. The grant switches on the same edge as the phase start pulse.
- `reset` mid-phase: takes effect next edge and overrides everything. Memory wren is forced to 0 immediately after that edge.

## Structure

- Package `rc4_pkg`:
  - `phase_t` enum, 3 bits: IDLE=0, INIT=1, SHUFFLE=2, DECRYPT=3, FOUND=4, EXHAUSTED=5.
  - `KEY_W` constant.
  - `S_ADDR_W`=8 and `S_DATA_W`=8.
- Sub-module `s_mem_port_mux`: purely combinational 3-requester grant mux, driven by `phase_t`. The FSM and key counter stay in the top.

## Test plan

- Reset, then idle 10 cycles -> all outputs 0, `secret_key`=0, `phase`=IDLE, no start pulses.
- `start`; init, shuffle and decrypt models each finish 5 cycles after their start pulse; `decrypt_ok`=1 -> pulses 1 cycle each at cycles 1, 7, 13; FOUND at cycle 19; `secret_key`=0.
- Decrypt fails for keys 0..2 and passes on key 3 -> `init_start` pulses 4 times; `found`=1 with `secret_key`=3.
- `KEY_START`=5, `KEY_MAX`=6, always fail -> keys 5, 6 tried; then EXHAUSTED, `secret_key`=6, `found`=0.
- Phase models hold finish as a level, plus a spurious `shuffle_finish` during INIT -> no skipped phase, no double pulse, grant tracks state; `mem_wren` only from the active requester.
- Assert `reset` during SHUFFLE with `shuffle_wren`=1 -> next cycle IDLE, `mem_wren`=0, key=`KEY_START`; `start` during `busy` is ignored.
